// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multicycle controller: FSM states, opcode/func7 constants,
// ALU operation codes and immediate-format selectors.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;

  // func3 -> ALU op for the func7=0 forms shared by R-type and I-ALU
  function automatic logic [3:0] base_alu_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu_op = ALU_ADD;
      3'b001:  base_alu_op = ALU_SLL;
      3'b010:  base_alu_op = ALU_SLT;
      3'b011:  base_alu_op = ALU_SLTU;
      3'b100:  base_alu_op = ALU_XOR;
      3'b101:  base_alu_op = ALU_SRL;
      3'b110:  base_alu_op = ALU_OR;
      default: base_alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational op/func3/func7 -> ALU control decode with instruction class and illegal flag.
// Zero latency, no flow control; CTRL_M_EXT_EN enables the func7=0000001 R-type group.
module alu_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [6:0]          op,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_source,
  output logic [2:0]          imm_source,
  output logic                is_load,
  output logic                is_store,
  output logic                is_branch,
  output logic                illegal
);

  logic [3:0] code;
  logic       m_ext;

  always_comb begin
    code       = ALU_ADD;
    m_ext      = 1'b0;
    alu_source = 1'b0;
    imm_source = IMM_I;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_R: begin
        case (func7)
          F7_BASE: code = base_alu_op(func3);
          F7_ALT: begin
            if (func3 == 3'b000)      code = ALU_SUB;
            else if (func3 == 3'b101) code = ALU_SRA;
            else                      illegal = 1'b1;
          end
`ifdef CTRL_M_EXT_EN
          F7_MEXT: m_ext = 1'b1;
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_I: begin
        code       = base_alu_op(func3);
        alu_source = 1'b1;
        // shift-immediates carry their shift kind in func7
        if (func3 == 3'b001 && func7 != F7_BASE) illegal = 1'b1;
        if (func3 == 3'b101) begin
          if (func7 == F7_ALT)       code = ALU_SRA;
          else if (func7 != F7_BASE) illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        is_load    = 1'b1;
        alu_source = 1'b1;
      end
      OP_STORE: begin
        is_store   = 1'b1;
        alu_source = 1'b1;
        imm_source = IMM_S;
      end
      OP_BRANCH: begin
        is_branch  = 1'b1;
        imm_source = IMM_B;
        case (func3[2:1])
          2'b00:   code = ALU_SUB;
          2'b10:   code = ALU_SLT;
          2'b11:   code = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    alu_op = ALU_OP_W'(code);
    if (m_ext) begin
      alu_op               = ALU_OP_W'({1'b1, func3});
      alu_op[ALU_OP_W-1]   = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with sticky TRAP.
// ALU 4, load 5, branch 3, store 4 cycles at zero wait; waits on mem_ready up to MEM_TIMEOUT.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                alu_zero,
  input  logic                alu_last_bit,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                addr_is_pc,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_source,
  output logic                reg_write,
  output logic                alu_source,
  output logic [2:0]          imm_source,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                trap,
  output logic [2:0]          state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               timeout, taken;

  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_alu_source, dec_is_load, dec_is_store, dec_is_branch, dec_illegal;
  logic [2:0]          dec_imm_source;

  alu_decoder #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .op         (op),
    .func3      (func3),
    .func7      (func7),
    .alu_op     (dec_alu_op),
    .alu_source (dec_alu_source),
    .imm_source (dec_imm_source),
    .is_load    (dec_is_load),
    .is_store   (dec_is_store),
    .is_branch  (dec_is_branch),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    cnt_inc    = cnt_q + CNT_W'(1);
    timeout    = (cnt_inc == CNT_W'(MEM_TIMEOUT));
    taken      = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    addr_is_pc = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    reg_write  = 1'b0;
    alu_source = 1'b0;
    imm_source = 3'd0;
    alu_op     = '0;
    trap       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        addr_is_pc = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DECODE: state_d = dec_illegal ? TRAP : EXECUTE;
      EXECUTE: begin
        alu_op     = dec_alu_op;
        alu_source = dec_alu_source;
        imm_source = dec_imm_source;
        if (dec_is_branch) begin
          // func3[2] picks the compare flag, func3[0] inverts the sense
          taken     = (func3[2] ? alu_last_bit : alu_zero) ^ func3[0];
          pc_write  = taken;
          pc_source = taken;
          state_d   = FETCH;
        end else if (dec_is_load || dec_is_store) begin
          state_d = MEM;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_write = dec_is_store;
        if (mem_ready) begin
          state_d = dec_is_store ? FETCH : WRITEBACK;
        end else if (timeout) begin
          state_d = TRAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      TRAP:    trap = 1'b1;
      default: state_d = TRAP;
    endcase

    if (rst) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      addr_is_pc = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_source  = 1'b0;
      reg_write  = 1'b0;
      alu_source = 1'b0;
      imm_source = 3'd0;
      alu_op     = '0;
      trap       = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words queued by
// the stimulus, popped and compared by an independent monitor on the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op, func7;
  logic [2:0] func3;
  logic       alu_zero, alu_last_bit, mem_ready;
  logic       mem_req, mem_write, addr_is_pc, ir_write, pc_write, pc_source, reg_write;
  logic       alu_source, trap;
  logic [2:0] imm_source, state;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .addr_is_pc(addr_is_pc),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source), .reg_write(reg_write),
    .alu_source(alu_source), .imm_source(imm_source), .alu_op(alu_op),
    .trap(trap), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_write, addr_is_pc, ir_write, pc_write, pc_source, reg_write;
    logic       alu_source;
    logic [2:0] imm;
    logic [3:0] aop;
    logic       trap;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  logic [6:0] p_op, p_f7;
  logic [2:0] p_f3;
  logic       p_zero, p_lb;

  function automatic exp_t ex_idle(input logic [2:0] st);
    exp_t e; e = '0; e.st = st; return e;
  endfunction
  function automatic exp_t ex_fetch(input logic rdy);
    exp_t e; e = '0; e.mem_req = 1'b1; e.addr_is_pc = 1'b1;
    e.ir_write = rdy; e.pc_write = rdy; return e;
  endfunction
  function automatic exp_t ex_exec(input logic [3:0] aop, input logic asrc,
                                   input logic [2:0] imm, input logic pcw);
    exp_t e; e = '0; e.st = 3'd2; e.aop = aop; e.alu_source = asrc; e.imm = imm;
    e.pc_write = pcw; e.pc_source = pcw; return e;
  endfunction
  function automatic exp_t ex_mem(input logic wr);
    exp_t e; e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.mem_write = wr; return e;
  endfunction
  function automatic exp_t ex_wb();
    exp_t e; e = '0; e.st = 3'd4; e.reg_write = 1'b1; return e;
  endfunction
  function automatic exp_t ex_trap();
    exp_t e; e = '0; e.st = 3'd5; e.trap = 1'b1; return e;
  endfunction

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input logic lb);
    p_op = o; p_f3 = f3; p_f7 = f7; p_zero = z; p_lb = lb;
  endtask

  // one clock: drive inputs just after the edge and queue the control word expected this cycle
  task automatic step(input string tag, input logic r, input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy;
    op = p_op; func3 = p_f3; func7 = p_f7; alu_zero = p_zero; alu_last_bit = p_lb;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  exp_t  mon_e, mon_a;
  string mon_t;

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a.st         = state;
      mon_a.mem_req    = mem_req;
      mon_a.mem_write  = mem_write;
      mon_a.addr_is_pc = addr_is_pc;
      mon_a.ir_write   = ir_write;
      mon_a.pc_write   = pc_write;
      mon_a.pc_source  = pc_source;
      mon_a.reg_write  = reg_write;
      mon_a.alu_source = alu_source;
      mon_a.imm        = imm_source;
      mon_a.aop        = alu_op;
      mon_a.trap       = trap;
      n_vec++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL %s: actual=%05h (state %0d alu_op %b trap %b) required=%05h (state %0d alu_op %b trap %b)",
                 mon_t, mon_a, mon_a.st, mon_a.aop, mon_a.trap, mon_e, mon_e.st, mon_e.aop, mon_e.trap);
      end
    end
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; op = '0; func3 = '0; func7 = '0;
    alu_zero = 1'b0; alu_last_bit = 1'b0;
    set_ir(7'b0, 3'b0, 7'b0, 1'b0, 1'b0);

    // reset wins over mem_ready
    step("rst0", 1, 1, ex_idle(3'd0));
    step("rst1", 1, 1, ex_idle(3'd0));

    set_ir(7'b0110011, 3'b000, 7'b0000000, 0, 0);
    step("add_f", 0, 1, ex_fetch(1));
    step("add_d", 0, 0, ex_idle(3'd1));
    step("add_e", 0, 0, ex_exec(4'b0000, 0, 3'd0, 0));
    step("add_w", 0, 0, ex_wb());

    // mem_ready outside FETCH/MEM is ignored
    set_ir(7'b0110011, 3'b000, 7'b0100000, 0, 0);
    step("sub_f", 0, 1, ex_fetch(1));
    step("sub_d", 0, 1, ex_idle(3'd1));
    step("sub_e", 0, 1, ex_exec(4'b0111, 0, 3'd0, 0));
    step("sub_w", 0, 1, ex_wb());

    set_ir(7'b1100011, 3'b001, 7'b0, 0, 0);
    step("bne_t_f", 0, 1, ex_fetch(1));
    step("bne_t_d", 0, 0, ex_idle(3'd1));
    step("bne_t_e", 0, 0, ex_exec(4'b0111, 0, 3'd2, 1));

    set_ir(7'b1100011, 3'b001, 7'b0, 1, 0);
    step("bne_n_f", 0, 1, ex_fetch(1));
    step("bne_n_d", 0, 0, ex_idle(3'd1));
    step("bne_n_e", 0, 0, ex_exec(4'b0111, 0, 3'd2, 0));

    set_ir(7'b1100011, 3'b110, 7'b0, 0, 1);
    step("bltu_f", 0, 1, ex_fetch(1));
    step("bltu_d", 0, 0, ex_idle(3'd1));
    step("bltu_e", 0, 0, ex_exec(4'b1001, 0, 3'd2, 1));

    set_ir(7'b1100011, 3'b101, 7'b0, 0, 1);
    step("bge_f", 0, 1, ex_fetch(1));
    step("bge_d", 0, 0, ex_idle(3'd1));
    step("bge_e", 0, 0, ex_exec(4'b1000, 0, 3'd2, 0));

    // load with three wait cycles in MEM
    set_ir(7'b0000011, 3'b010, 7'b0, 0, 0);
    step("ld_f", 0, 1, ex_fetch(1));
    step("ld_d", 0, 0, ex_idle(3'd1));
    step("ld_e", 0, 1, ex_exec(4'b0000, 1, 3'd0, 0));
    for (int i = 0; i < 3; i++) step("ld_mwait", 0, 0, ex_mem(0));
    step("ld_mdone", 0, 1, ex_mem(0));
    step("ld_w", 0, 0, ex_wb());

    set_ir(7'b0100011, 3'b010, 7'b0, 0, 0);
    step("st_f", 0, 1, ex_fetch(1));
    step("st_d", 0, 0, ex_idle(3'd1));
    step("st_e", 0, 0, ex_exec(4'b0000, 1, 3'd1, 0));
    step("st_m", 0, 1, ex_mem(1));

    set_ir(7'b0010011, 3'b101, 7'b0100000, 0, 0);
    step("srai_f", 0, 1, ex_fetch(1));
    step("srai_d", 0, 0, ex_idle(3'd1));
    step("srai_e", 0, 0, ex_exec(4'b0011, 1, 3'd0, 0));
    step("srai_w", 0, 0, ex_wb());

    set_ir(7'b0010011, 3'b011, 7'b0, 0, 0);
    step("sltiu_fw0", 0, 0, ex_fetch(0));
    step("sltiu_fw1", 0, 0, ex_fetch(0));
    step("sltiu_f", 0, 1, ex_fetch(1));
    step("sltiu_d", 0, 0, ex_idle(3'd1));
    step("sltiu_e", 0, 0, ex_exec(4'b1001, 1, 3'd0, 0));
    step("sltiu_w", 0, 0, ex_wb());

    // reset while a load waits in MEM: no writeback may follow
    set_ir(7'b0000011, 3'b010, 7'b0, 0, 0);
    step("ldr_f", 0, 1, ex_fetch(1));
    step("ldr_d", 0, 0, ex_idle(3'd1));
    step("ldr_e", 0, 0, ex_exec(4'b0000, 1, 3'd0, 0));
    step("ldr_m", 0, 0, ex_mem(0));
    step("ldr_rst", 1, 1, ex_idle(3'd3));
    step("ldr_after", 0, 0, ex_fetch(0));

    set_ir(7'b0010011, 3'b001, 7'b0100000, 0, 0);
    step("slli_f", 0, 1, ex_fetch(1));
    step("slli_d", 0, 0, ex_idle(3'd1));
    step("slli_t0", 0, 1, ex_trap());
    step("slli_t1", 0, 0, ex_trap());
    step("slli_rst", 1, 0, ex_idle(3'd5));

    // fetch timeout after four wait cycles
    for (int i = 0; i < 4; i++) step("to_fwait", 0, 0, ex_fetch(0));
    step("to_t0", 0, 1, ex_trap());
    step("to_t1", 0, 0, ex_trap());
    step("to_rst", 1, 0, ex_idle(3'd5));
    step("to_rec", 0, 0, ex_fetch(0));

    set_ir(7'b1110011, 3'b000, 7'b0, 0, 0);
    step("sys_f", 0, 1, ex_fetch(1));
    step("sys_d", 0, 0, ex_idle(3'd1));
    step("sys_t", 0, 0, ex_trap());
    step("sys_rst", 1, 0, ex_idle(3'd5));

    set_ir(7'b0110011, 3'b000, 7'b0000001, 0, 0);
    step("mul_f", 0, 1, ex_fetch(1));
    step("mul_d", 0, 0, ex_idle(3'd1));
`ifdef CTRL_M_EXT_EN
    step("mul_e", 0, 0, ex_exec(4'b1000, 0, 3'd0, 0));
    step("mul_w", 0, 0, ex_wb());
    step("mul_rst", 1, 0, ex_idle(3'd0));
`else
    step("mul_t", 0, 0, ex_trap());
    step("mul_rst", 1, 0, ex_idle(3'd5));
`endif

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected words left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
